// File: rtl/neuron_pkg.sv
// Shared neuron types and constants: activation limits, operand widths, FSM
// state encoding and the hard-limit function used by act_clamp.
package neuron_pkg;

  localparam int ACT_MAX = 127;
  localparam int ACT_MIN = -127;
  localparam int PROD_W  = 17;
  localparam int OPX_W   = 9;
  localparam int ACT_W   = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Returns {sat, y}; the symmetric limit keeps -128 out of the activation range.
  function automatic logic [ACT_W:0] clamp_act(input logic signed [31:0] acc);
    logic [ACT_W:0] res;
    if (acc > ACT_MAX)
      res = {1'b1, 8'h7F};
    else if (acc < ACT_MIN)
      res = {1'b1, 8'h81};
    else
      res = {1'b0, acc[ACT_W-1:0]};
    return res;
  endfunction

endpackage

// File: rtl/act_clamp.sv
// Combinational hard limiter: ACC_W-bit signed sum to an 8-bit activation plus
// a saturation flag. ACC_W must be below 32.
module act_clamp
  import neuron_pkg::*;
#(
  parameter int ACC_W = 22
) (
  input  logic [ACC_W-1:0] acc,
  output logic [ACT_W-1:0] y,
  output logic             sat
);

  logic [31:0] acc_ext;

  assign acc_ext  = {{(32-ACC_W){acc[ACC_W-1]}}, acc};
  assign {sat, y} = clamp_act($signed(acc_ext));

endmodule

// File: rtl/mitchell_mac_sequencer.sv
// Serial neuron MAC: drives one external approximate multiplier per synapse,
// accumulates, clamps. Define MAC_PROD_REG_EN to register the product first.
module mitchell_mac_sequencer
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 3,
  parameter int ACC_W    = 22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*N_INPUTS-1:0] x_vec,
  input  logic [9*N_INPUTS-1:0] w_vec,
  output logic [OPX_W-1:0]      mul_x,
  output logic [OPX_W-1:0]      mul_y,
  input  logic [PROD_W-1:0]     mul_p,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACT_W-1:0]      y,
  output logic                  sat,
  output logic                  busy
);

  localparam int IDX_W = $clog2(N_INPUTS + 1);
`ifdef MAC_PROD_REG_EN
  localparam int LAST = N_INPUTS;
`else
  localparam int LAST = N_INPUTS - 1;
`endif

  state_t                  state;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] add_term;
  logic [7:0]              x_r  [N_INPUTS];
  logic [8:0]              w_r  [N_INPUTS];
  logic [7:0]              x_el [N_INPUTS];
  logic [8:0]              w_el [N_INPUTS];
  logic [ACT_W-1:0]        clamp_y;
  logic                    clamp_sat;

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
    assign x_el[gi] = x_vec[8*gi +: 8];
    assign w_el[gi] = w_vec[9*gi +: 9];
  end

  always_comb begin
    mul_x = '0;
    mul_y = '0;
    if (state == RUN) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (idx == IDX_W'(i)) begin
          mul_x = {x_r[i][7], x_r[i]};
          mul_y = w_r[i];
        end
      end
    end
  end

`ifdef MAC_PROD_REG_EN
  logic [PROD_W-1:0] prod_r;
  logic              prod_v;
  // The product issued last cycle is added now; prod_v masks the first RUN cycle.
  assign add_term = prod_v ? {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r} : '0;
`else
  assign add_term = {{(ACC_W-PROD_W){mul_p[PROD_W-1]}}, mul_p};
`endif

  assign acc_next = acc + add_term;
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  act_clamp #(.ACC_W(ACC_W)) u_clamp (
    .acc (acc_next),
    .y   (clamp_y),
    .sat (clamp_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      y         <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < N_INPUTS; i++) begin
        x_r[i] <= '0;
        w_r[i] <= '0;
      end
`ifdef MAC_PROD_REG_EN
      prod_r    <= '0;
      prod_v    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r   <= x_el;
            w_r   <= w_el;
            acc   <= '0;
            idx   <= '0;
            state <= RUN;
`ifdef MAC_PROD_REG_EN
            prod_v <= 1'b0;
`endif
          end
        end
        RUN: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
`ifdef MAC_PROD_REG_EN
          prod_r <= mul_p;
          prod_v <= (idx < IDX_W'(N_INPUTS));
`endif
          if (idx == IDX_W'(LAST)) begin
            y         <= clamp_y;
            sat       <= clamp_sat;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mitchell_mac_sequencer.sv
// Directed bench: Mitchell multiplier model on mul_p, scoreboard of expected
// activations, immediate-assertion checks with one summary line.
module tb_mitchell_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] x_vec;
  logic [26:0] w_vec;
  logic [8:0]  mul_x;
  logic [8:0]  mul_y;
  logic [16:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  y;
  logic        sat;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

`ifdef MAC_PROD_REG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  always #5 clk = ~clk;

  mitchell_mac_sequencer #(.N_INPUTS(3), .ACC_W(22)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_vec     (x_vec),
    .w_vec     (w_vec),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .sat       (sat),
    .busy      (busy)
  );

  // Mitchell log-domain approximation with 16 fractional bits, truncating.
  function automatic logic signed [16:0] mitchell(input logic signed [8:0] a,
                                                  input logic signed [8:0] b);
    longint ma, mb, fa, fb, fs, p;
    int ka, kb;
    ma = (a < 0) ? -longint'(a) : longint'(a);
    mb = (b < 0) ? -longint'(b) : longint'(b);
    if (ma == 0 || mb == 0) return '0;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 10; i++) begin
      if ((ma >> i) != 0) ka = i;
      if ((mb >> i) != 0) kb = i;
    end
    fa = ((ma << 16) >> ka) - 65536;
    fb = ((mb << 16) >> kb) - 65536;
    fs = fa + fb;
    if (fs < 65536) p = ((65536 + fs) << (ka + kb)) >> 16;
    else            p = (fs << (ka + kb + 1)) >> 16;
    if ((a < 0) != (b < 0)) p = -p;
    return 17'(p);
  endfunction

  always_comb mul_p = mitchell($signed(mul_x), $signed(mul_y));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_vec(input logic [23:0] xv, input logic [26:0] wv,
                         input logic [7:0] exp_y, input logic exp_sat, input int hold);
    int cyc;
    logic [8:0] e;
    logic [7:0] xe;
    chk("in_ready_idle", in_ready, 1);
    x_vec     = xv;
    w_vec     = wv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back({exp_sat, exp_y});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 12) begin
      if (cyc - 1 < 3) begin
        xe = xv[8*(cyc-1) +: 8];
        chk("mul_x_run", mul_x, {xe[7], xe});
        chk("mul_y_run", mul_y, wv[9*(cyc-1) +: 9]);
      end else begin
        chk("mul_x_tail", mul_x, 0);
      end
      chk("in_ready_run", in_ready, 0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, LAT);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
    chk("y", y, e[7:0]);
    chk("sat", sat, e[8]);
    chk("mul_x_done", mul_x, 0);
    chk("mul_y_done", mul_y, 0);
    for (int h = 0; h < hold; h++) begin
      chk("y_hold", y, e[7:0]);
      chk("sat_hold", sat, e[8]);
      chk("valid_hold", out_valid, 1);
      chk("in_ready_hold", in_ready, 0);
      chk("busy_hold", busy, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (hold > 0) @(negedge clk);
    @(negedge clk);
    chk("valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    $display("vector x=%h w=%h y=%h sat=%0d latency=%0d", xv, wv, e[7:0], e[8], cyc);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x_vec     = '0;
    w_vec     = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_sat", sat, 0);
    chk("rst_mul_x", mul_x, 0);
    chk("rst_mul_y", mul_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_vec({8'd3, 8'd5, 8'd10}, {9'd8, 9'h1F3, 9'd4}, 8'd4, 1'b0, 0);
    run_vec({8'h7F, 8'h80, 8'h7F}, {9'd8, 9'h1F3, 9'd4}, 8'h7F, 1'b1, 0);
    run_vec({8'h9C, 8'h64, 8'h9C}, {9'd8, 9'h1F3, 9'd4}, 8'h81, 1'b1, 0);
    run_vec({8'd3, 8'd5, 8'd10}, {9'd8, 9'h1F3, 9'd4}, 8'd4, 1'b0, 5);
    run_vec({8'd3, 8'd2, 8'd1}, {9'd1, 9'd1, 9'd1}, 8'd6, 1'b0, 0);
    run_vec({8'd0, 8'd0, 8'd0}, {9'd8, 9'h1F3, 9'd4}, 8'd0, 1'b0, 0);
    run_vec({8'd0, 8'd0, 8'hFF}, {9'd0, 9'd0, 9'd1}, 8'hFF, 1'b0, 0);

    // Abort a vector while idx=1, then confirm nothing leaks into the next one.
    x_vec    = {8'h7F, 8'h7F, 8'h7F};
    w_vec    = {9'd100, 9'd100, 9'd100};
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_mul_x_idx1", mul_x, 9'h07F);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_mul_x", mul_x, 0);
    $display("reset asserted mid-RUN");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec({8'd3, 8'd5, 8'd10}, {9'd8, 9'h1F3, 9'd4}, 8'd4, 1'b0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
